cmul_sched: RTL and testbench
=============================

# cmul_sched

Round-robin scheduler that shares one small-constant multiplier (`cmul`) among `NREQ` requesters in the BN254 datapath. It accepts (mode, operand, tag) requests over valid/ready and drives the multiplier's `mode` and `din`. It realigns `cmul.dout` after the multiplier's fixed latency and returns results in issue order through a credit-protected output FIFO. It also rejects modes the multiplier does not implement.

## Interface
- `NREQ`, 4, number of requesters (≥2)
- `DIN_W`, 272, operand width (matches the multiplier's `din`)
- `DOUT_W`, 288, result width (matches the multiplier's `dout`)
- `TAG_W`, 4, opaque requester tag width
- `LATENCY`, 1, latency of the attached `cmul` instance (0, 1 or 2)
- `FIFO_DEPTH`, 4, output FIFO entries; must be ≥ `LATENCY`+2 for full throughput, ≥1 for correctness
- `clk` in 1, single clock
- `rstn` in 1, asynchronous active-low reset
- `req_valid` in NREQ, per-requester request valid
- `req_ready` out NREQ, per-requester accept (one-hot or zero)
- `req_mode` in NREQ*3, per-requester mode, slice i = [3i+2:3i]
- `req_din` in NREQ*DIN_W, per-requester operand
- `req_tag` in NREQ*TAG_W, per-requester tag
- `cm_mode` out 3, to `cmul.mode`
- `cm_din` out DIN_W, to `cmul.din`
- `cm_dout` in DOUT_W, from `cmul.dout`
- `resp_valid` out 1, head of output FIFO valid
- `resp_ready` in 1, consumer accept
- `resp_dout` out DOUT_W, result
- `resp_id` out clog2(NREQ), index of the originating requester
- `resp_tag` out TAG_W, echoed tag
- `resp_err` out 1, request had an illegal mode
- `busy` out 1, outstanding count ≠ 0

## Operation
- Legal modes: 1 (×1), 2 (×2), 3 (×3), 4 (×4), 6 (×6). Modes 0, 5 and 7 are illegal.
- Arbitration: the round-robin pointer `rr` is reset to 0. The grant goes to the first i with `req_valid[i]` = 1, searching from `rr` upward with wrap-around.
  - The grant is issued only when `outstanding` < `FIFO_DEPTH`.
  - On an issue, `rr` becomes (granted+1) mod NREQ. With no issue, `rr` holds.
- `req_ready[g]` = 1 only for the granted index in an issue cycle. It is combinational from `req_valid`, `rr` and `outstanding`. It never depends on `resp_ready`.
- Legal issue: `cm_mode` = the requester's mode and `cm_din` = its operand.
- Illegal issue and idle cycle: `cm_mode` = 0 and `cm_din` = 0.
- Issue pipeline: `LATENCY`-deep shift of {valid, err, id, tag}. At stage `LATENCY` the entry is pushed into the FIFO.
  - Legal entries carry `dout` = `cm_dout`.
  - Err entries carry `dout` = 0 and `err` = 1, and occupy their slot so ordering is preserved.
- FIFO: `resp_valid` = not empty. A pop happens when `resp_valid` && `resp_ready`.
- `outstanding` counter (in-flight plus FIFO occupancy):
  - +1 on issue, −1 on pop.
  - Issue and pop in the same cycle leave it unchanged.
  - It never exceeds `FIFO_DEPTH`, so the FIFO never overflows. A push to a full FIFO is impossible by construction; assert this in the bench.
- Responses leave in issue order. `resp_*` is held stable while `resp_valid` && !`resp_ready`.
- Reset (asynchronous, any time including mid-operation) clears:
  - the pipeline valids, FIFO pointers, `outstanding` and `rr`.
  - `resp_valid`, `busy`, `resp_err` and `req_ready` go to 0. `req_ready` is forced 0 while `rstn` = 0.
  - `resp_dout`, `resp_id` and `resp_tag` read 0.
  - In-flight requests are discarded with no response.

## Timing
- Request handshake in cycle t: `cm_mode`/`cm_din` are valid in cycle t.
- The result is sampled from `cm_dout` in cycle t+`LATENCY` and written at the end of that cycle. `resp_valid` rises in cycle t+`LATENCY`+1.
- A pop in cycle p frees its credit from cycle p+1 (registered counter). There is no same-cycle credit reuse.
- With `resp_ready` held 1 and `FIFO_DEPTH` ≥ `LATENCY`+2, throughput is one issue and one response per cycle.
- `busy` is registered and follows `outstanding` at the next edge.

## Test plan
- Single op, LATENCY=1: requester 2 sends `mode`=6, `din`=5, `tag`=3 at t. Required: `req_ready[2]`=1 at t. `resp_valid` at t+2 with `dout`=30, `id`=2, `tag`=3, `err`=0. `busy` is 1 from t+1 until the cycle after the pop.
- Fairness: all 4 requesters hold valid with modes 1, 2, 3, 4 and `din`=7 each, resp_ready=1. Required: grants in order 0,1,2,3,0,…. Responses 7, 14, 21, 28 repeating, one per cycle.
- Illegal mode: requester 1 sends `mode`=5, `din`=9, between two legal ops. Required: `cm_mode`=0 and `cm_din`=0 in its issue cycle. Its response arrives in order with `err`=1 and `dout`=0. Neighbouring results are correct.
- Backpressure: FIFO_DEPTH=4, `resp_ready`=0, requester 0 streams. Required: exactly 4 accepts, then `req_ready`=0. Raising `resp_ready` for 1 cycle allows one new accept on the following cycle. No data is lost or duplicated.
- Simultaneous issue and pop with `outstanding`=FIFO_DEPTH−1: required `outstanding` unchanged and continuous streaming with no bubble.
- Reset mid-stream: drop `rstn` asynchronously with 3 ops in flight. Required: outputs go to 0 immediately and no stale responses appear after release. The first post-reset grant goes to the lowest valid index.

Source files
------------

// File: rtl/cmul_sched_if.sv
// cmul_sched_if: request and response handshake bundle for cmul_sched.
//   req_valid/req_ready : per-requester valid/ready, ready is one-hot or zero
//   req_mode/din/tag    : per-requester packed fields, slice i belongs to requester i
//   resp_valid/ready    : head-of-FIFO handshake towards the consumer
//   resp_dout/id/tag/err: result, originating requester, echoed tag, illegal-mode flag
// modport slave is the scheduler side, modport master the requester/consumer side.
interface cmul_sched_if #(
    parameter int NREQ   = 4,
    parameter int DIN_W  = 272,
    parameter int DOUT_W = 288,
    parameter int TAG_W  = 4
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*3-1:0]     req_mode;
    logic [NREQ*DIN_W-1:0] req_din;
    logic [NREQ*TAG_W-1:0] req_tag;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DOUT_W-1:0]     resp_dout;
    logic [ID_W-1:0]       resp_id;
    logic [TAG_W-1:0]      resp_tag;
    logic                  resp_err;

    modport slave (
        input  req_valid, req_mode, req_din, req_tag, resp_ready,
        output req_ready, resp_valid, resp_dout, resp_id, resp_tag, resp_err
    );

    modport master (
        output req_valid, req_mode, req_din, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_dout, resp_id, resp_tag, resp_err
    );
endinterface

// File: rtl/cmul_sched.sv
// cmul_sched: round-robin scheduler sharing one small-constant multiplier
// (cmul) among NREQ requesters. Requests are granted only while a result
// slot is guaranteed in the output FIFO, so results return in issue order
// and the FIFO can never overflow.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : cmul_sched_if.slave, request and response handshakes
//   cm_mode   : to cmul.mode (0 when idle or on an illegal-mode issue)
//   cm_din    : to cmul.din  (0 when idle or on an illegal-mode issue)
//   cm_dout   : from cmul.dout, valid LATENCY cycles after issue
//   busy      : registered, 1 while any request is in flight or queued
module cmul_sched #(
    parameter int NREQ       = 4,
    parameter int DIN_W      = 272,
    parameter int DOUT_W     = 288,
    parameter int TAG_W      = 4,
    parameter int LATENCY    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rstn,
    cmul_sched_if.slave        bus,
    output logic [2:0]         cm_mode,
    output logic [DIN_W-1:0]   cm_din,
    input  logic [DOUT_W-1:0]  cm_dout,
    output logic               busy
);
    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    function automatic logic mode_legal(input logic [2:0] m);
        return (m == 3'd1) || (m == 3'd2) || (m == 3'd3) || (m == 3'd4) || (m == 3'd6);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [2:0]       mode_a [NREQ];
    logic [DIN_W-1:0] din_a  [NREQ];
    logic [TAG_W-1:0] tag_a  [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign mode_a[g] = bus.req_mode[3*g +: 3];
        assign din_a[g]  = bus.req_din[DIN_W*g +: DIN_W];
        assign tag_a[g]  = bus.req_tag[TAG_W*g +: TAG_W];
    end

    logic [ID_W-1:0]  rr, rr_nxt, grant_idx;
    logic             grant_found, issue, pop;
    logic [CNT_W-1:0] outstanding, out_nxt;
    int               scan_j;

    // Stage 0: arbitration, search upward from rr with wrap-around
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_j      = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_j = int'(rr) + k;
            if (scan_j >= NREQ) scan_j = scan_j - NREQ;
            if (!grant_found && bus.req_valid[scan_j[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_j[ID_W-1:0];
            end
        end
    end

    // Credit check: outstanding covers both in-flight and queued entries
    assign issue  = grant_found && rstn && (outstanding < CNT_W'(FIFO_DEPTH));
    assign rr_nxt = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);

    always_comb begin
        bus.req_ready = '0;
        if (issue) bus.req_ready[grant_idx] = 1'b1;
    end

    logic             vld_p0, err_p0;
    logic [ID_W-1:0]  id_p0;
    logic [TAG_W-1:0] tag_p0;
    logic [2:0]       mode_sel;

    assign mode_sel = mode_a[grant_idx];
    assign vld_p0   = issue;
    assign err_p0   = !mode_legal(mode_sel);
    assign id_p0    = grant_idx;
    assign tag_p0   = tag_a[grant_idx];
    assign cm_mode  = (issue && !err_p0) ? mode_sel : 3'd0;
    assign cm_din   = (issue && !err_p0) ? din_a[grant_idx] : '0;

    logic             push_vld, push_err;
    logic [ID_W-1:0]  push_id;
    logic [TAG_W-1:0] push_tag;

    // Stages 1..LATENCY: track each issue alongside the multiplier pipeline
    if (LATENCY == 0) begin : g_lat0
        assign push_vld = vld_p0;
        assign push_err = err_p0;
        assign push_id  = id_p0;
        assign push_tag = tag_p0;
    end else begin : g_latn
        logic             vld_pn [LATENCY];
        logic             err_pn [LATENCY];
        logic [ID_W-1:0]  id_pn  [LATENCY];
        logic [TAG_W-1:0] tag_pn [LATENCY];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int s = 0; s < LATENCY; s++) vld_pn[s] <= 1'b0;
            end else begin
                vld_pn[0] <= vld_p0;
                for (int s = 1; s < LATENCY; s++) vld_pn[s] <= vld_pn[s-1];
            end
        end

        always_ff @(posedge clk) begin
            err_pn[0] <= err_p0;
            id_pn[0]  <= id_p0;
            tag_pn[0] <= tag_p0;
            for (int s = 1; s < LATENCY; s++) begin
                err_pn[s] <= err_pn[s-1];
                id_pn[s]  <= id_pn[s-1];
                tag_pn[s] <= tag_pn[s-1];
            end
        end

        assign push_vld = vld_pn[LATENCY-1];
        assign push_err = err_pn[LATENCY-1];
        assign push_id  = id_pn[LATENCY-1];
        assign push_tag = tag_pn[LATENCY-1];
    end

    // Output FIFO: entries written when the realigned result arrives
    logic [DOUT_W-1:0] dout_mem [FIFO_DEPTH];
    logic              err_mem  [FIFO_DEPTH];
    logic [ID_W-1:0]   id_mem   [FIFO_DEPTH];
    logic [TAG_W-1:0]  tag_mem  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;

    assign bus.resp_valid = (fifo_cnt != '0);
    assign pop            = bus.resp_valid && bus.resp_ready;

    always_comb begin
        out_nxt = outstanding;
        if (issue && !pop)      out_nxt = outstanding + CNT_W'(1);
        else if (!issue && pop) out_nxt = outstanding - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            outstanding <= '0;
            rr          <= '0;
            busy        <= 1'b0;
        end else begin
            if (push_vld) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)      rd_ptr <= ptr_inc(rd_ptr);
            if (push_vld && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
            else if (!push_vld && pop) fifo_cnt <= fifo_cnt - CNT_W'(1);
            outstanding <= out_nxt;
            busy        <= (out_nxt != '0);
            if (issue) rr <= rr_nxt;
        end
    end

    // Err entries keep their slot but never expose whatever cmul produced for mode 0
    always_ff @(posedge clk) begin
        if (push_vld) begin
            dout_mem[wr_ptr] <= push_err ? '0 : cm_dout;
            err_mem[wr_ptr]  <= push_err;
            id_mem[wr_ptr]   <= push_id;
            tag_mem[wr_ptr]  <= push_tag;
        end
    end

    // Data storage is unreset; gating on resp_valid makes the outputs read 0 when empty
    assign bus.resp_dout = bus.resp_valid ? dout_mem[rd_ptr] : '0;
    assign bus.resp_err  = bus.resp_valid && err_mem[rd_ptr];
    assign bus.resp_id   = bus.resp_valid ? id_mem[rd_ptr] : '0;
    assign bus.resp_tag  = bus.resp_valid ? tag_mem[rd_ptr] : '0;
endmodule

// File: tb/tb_cmul_sched.sv
module tb_cmul_sched;
    localparam int NREQ       = 4;
    localparam int DIN_W      = 272;
    localparam int DOUT_W     = 288;
    localparam int TAG_W      = 4;
    localparam int LATENCY    = 1;
    localparam int FIFO_DEPTH = 4;

    logic              clk;
    logic              rstn;
    logic [2:0]        cm_mode;
    logic [DIN_W-1:0]  cm_din;
    logic [DOUT_W-1:0] cm_dout;
    logic              busy;
    logic              full_push_seen;
    int                tests;
    int                fails;

    cmul_sched_if #(.NREQ(NREQ), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .TAG_W(TAG_W)) bus ();

    cmul_sched #(
        .NREQ(NREQ), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .TAG_W(TAG_W),
        .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus),
        .cm_mode(cm_mode),
        .cm_din(cm_din),
        .cm_dout(cm_dout),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle multiplier; unimplemented modes return junk so the err path must zero it
    always @(posedge clk) begin
        case (cm_mode)
            3'd1, 3'd2, 3'd3, 3'd4, 3'd6: cm_dout <= DOUT_W'(cm_din) * DOUT_W'(cm_mode);
            default:                      cm_dout <= DOUT_W'(32'hDEAD_BEEF);
        endcase
    end

    initial full_push_seen = 1'b0;
    always @(posedge clk) begin
        if (rstn && dut.push_vld && int'(dut.fifo_cnt) == FIFO_DEPTH && !dut.pop)
            full_push_seen <= 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int i, input logic [2:0] m, input int d, input logic [TAG_W-1:0] t);
        bus.req_mode[3*i +: 3]         = m;
        bus.req_din[DIN_W*i +: DIN_W]  = DIN_W'(d);
        bus.req_tag[TAG_W*i +: TAG_W]  = t;
    endtask

    task automatic do_reset();
        rstn           = 1'b0;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 3'd2, 11 + i, 4'(i));
        bus.req_valid  = '1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        #1;
        tests++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL rst_ready: got %b want 0000", bus.req_ready); end
        tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
        tests++; if (bus.resp_dout !== '0 || bus.resp_id !== 2'd0 || bus.resp_tag !== 4'd0 || bus.resp_err !== 1'b0) begin
            fails++; $display("FAIL rst_resp_fields: got %0h/%0d/%0d/%b want 0/0/0/0", bus.resp_dout, bus.resp_id, bus.resp_tag, bus.resp_err); end
        tests++; if (cm_mode !== 3'd0 || cm_din !== '0) begin fails++; $display("FAIL rst_cm: got %0d/%0h want 0/0", cm_mode, cm_din); end
    endtask

    task automatic test_single();
        do_reset();
        set_req(2, 3'd6, 5, 4'd3);
        bus.req_valid  = 4'b0100;
        bus.resp_ready = 1'b1;
        #1;
        tests++; if (bus.req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready: got %b want 0100", bus.req_ready); end
        tests++; if (cm_mode !== 3'd6 || cm_din !== DIN_W'(5)) begin fails++; $display("FAIL single_cm: got %0d/%0d want 6/5", cm_mode, cm_din); end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        tests++; if (busy !== 1'b1 || bus.resp_valid !== 1'b0) begin fails++; $display("FAIL single_t1: got busy %b valid %b want 1 0", busy, bus.resp_valid); end
        @(negedge clk);
        #1;
        tests++; if (bus.resp_valid !== 1'b1 || bus.resp_dout !== DOUT_W'(30)) begin fails++; $display("FAIL single_dout: got %b/%0d want 1/30", bus.resp_valid, bus.resp_dout); end
        tests++; if (bus.resp_id !== 2'd2 || bus.resp_tag !== 4'd3 || bus.resp_err !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL single_meta: got id %0d tag %0d err %b busy %b want 2 3 0 1", bus.resp_id, bus.resp_tag, bus.resp_err, busy); end
        @(negedge clk);
        #1;
        tests++; if (bus.resp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL single_after_pop: got valid %b busy %b want 0 0", bus.resp_valid, busy); end
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0]   exp_rdy;
        logic [DOUT_W-1:0] exp_d;
        logic [1:0]        exp_id;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 3'(i + 1), 7, 4'(i));
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) begin
                exp_rdy = 4'(1 << (c % 4));
                tests++; if (bus.req_ready !== exp_rdy) begin fails++; $display("FAIL fair_grant c%0d: got %b want %b", c, bus.req_ready, exp_rdy); end
            end
            if (c >= 2) begin
                exp_d  = DOUT_W'(7 * (((c - 2) % 4) + 1));
                exp_id = 2'((c - 2) % 4);
                tests++; if (bus.resp_valid !== 1'b1 || bus.resp_dout !== exp_d || bus.resp_id !== exp_id) begin
                    fails++; $display("FAIL fair_resp c%0d: got %b/%0d/%0d want 1/%0d/%0d", c, bus.resp_valid, bus.resp_dout, bus.resp_id, exp_d, exp_id); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        logic [NREQ-1:0]   vseq [3];
        logic [2:0]        mseq [3];
        logic [DIN_W-1:0]  dseq [3];
        logic [DOUT_W-1:0] rseq [3];
        logic              eseq [3];
        vseq = '{4'b0111, 4'b0110, 4'b0100};
        mseq = '{3'd2, 3'd0, 3'd3};
        dseq = '{DIN_W'(3), DIN_W'(0), DIN_W'(4)};
        rseq = '{DOUT_W'(6), DOUT_W'(0), DOUT_W'(12)};
        eseq = '{1'b0, 1'b1, 1'b0};
        do_reset();
        set_req(0, 3'd2, 3, 4'd0);
        set_req(1, 3'd5, 9, 4'd1);
        set_req(2, 3'd3, 4, 4'd2);
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.req_valid = (c < 3) ? vseq[c] : 4'h0;
            #1;
            if (c < 3) begin
                tests++; if (bus.req_ready !== 4'(1 << c) || cm_mode !== mseq[c] || cm_din !== dseq[c]) begin
                    fails++; $display("FAIL illegal_issue c%0d: got %b/%0d/%0d want %b/%0d/%0d", c, bus.req_ready, cm_mode, cm_din, 4'(1 << c), mseq[c], dseq[c]); end
            end
            if (c >= 2) begin
                tests++; if (bus.resp_valid !== 1'b1 || bus.resp_dout !== rseq[c-2] || bus.resp_err !== eseq[c-2] || bus.resp_id !== 2'(c - 2)) begin
                    fails++; $display("FAIL illegal_resp c%0d: got %b/%0h/err%b/id%0d want 1/%0h/err%b/id%0d", c, bus.resp_valid, bus.resp_dout, bus.resp_err, bus.resp_id, rseq[c-2], eseq[c-2], c - 2); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [NREQ-1:0]   exp_rdy;
        logic [DOUT_W-1:0] exp_d;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            set_req(0, 3'd1, (c < 4) ? 100 + c : 104, 4'd5);
            bus.req_valid  = 4'b0001;
            bus.resp_ready = (c == 6);
            #1;
            exp_rdy = (c < 4 || c == 7) ? 4'b0001 : 4'b0000;
            tests++; if (bus.req_ready !== exp_rdy) begin fails++; $display("FAIL bp_ready c%0d: got %b want %b", c, bus.req_ready, exp_rdy); end
            if (c == 5 || c == 6) begin
                tests++; if (bus.resp_valid !== 1'b1 || bus.resp_dout !== DOUT_W'(100) || bus.resp_tag !== 4'd5) begin
                    fails++; $display("FAIL bp_hold c%0d: got %b/%0d/%0d want 1/100/5", c, bus.resp_valid, bus.resp_dout, bus.resp_tag); end
            end
            @(negedge clk);
        end
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            exp_d = DOUT_W'(101 + c);
            if (c < 4) begin
                tests++; if (bus.resp_valid !== 1'b1 || bus.resp_dout !== exp_d) begin fails++; $display("FAIL bp_drain %0d: got %b/%0d want 1/%0d", c, bus.resp_valid, bus.resp_dout, exp_d); end
            end else begin
                tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL bp_empty: got %b want 0", bus.resp_valid); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [DOUT_W-1:0] exp_d;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            set_req(0, 3'd2, 200 + c, 4'd0);
            bus.req_valid  = (c < 8) ? 4'b0001 : 4'b0000;
            bus.resp_ready = (c >= 3);
            #1;
            if (c < 8) begin
                tests++; if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL b2b_ready c%0d: got %b want 0001", c, bus.req_ready); end
            end
            if (c >= 3 && c < 8) begin
                tests++; if (int'(dut.outstanding) !== FIFO_DEPTH - 1) begin fails++; $display("FAIL b2b_outstanding c%0d: got %0d want %0d", c, dut.outstanding, FIFO_DEPTH - 1); end
            end
            if (c >= 3) begin
                exp_d = DOUT_W'(2 * (200 + c - 3));
                tests++; if (bus.resp_valid !== 1'b1 || bus.resp_dout !== exp_d) begin fails++; $display("FAIL b2b_resp c%0d: got %b/%0d want 1/%0d", c, bus.resp_valid, bus.resp_dout, exp_d); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        set_req(0, 3'd4, 10, 4'd1);
        set_req(1, 3'd3, 5, 4'd9);
        for (int c = 0; c < 3; c++) begin
            bus.req_valid = 4'b0001;
            @(negedge clk);
        end
        bus.req_valid = '0;
        #1;
        tests++; if (bus.resp_valid !== 1'b1 || bus.resp_dout !== DOUT_W'(40)) begin fails++; $display("FAIL mid_pre: got %b/%0d want 1/40", bus.resp_valid, bus.resp_dout); end
        #2;
        rstn          = 1'b0;
        bus.req_valid = 4'hF;
        #1;
        tests++; if (bus.resp_valid !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 4'b0000 || cm_mode !== 3'd0) begin
            fails++; $display("FAIL mid_async: got valid %b busy %b ready %b mode %0d want 0 0 0000 0", bus.resp_valid, busy, bus.req_ready, cm_mode); end
        tests++; if (bus.resp_dout !== '0 || bus.resp_id !== 2'd0 || bus.resp_tag !== 4'd0 || bus.resp_err !== 1'b0) begin
            fails++; $display("FAIL mid_fields: got %0h/%0d/%0d/%b want 0/0/0/0", bus.resp_dout, bus.resp_id, bus.resp_tag, bus.resp_err); end
        @(negedge clk);
        rstn           = 1'b1;
        bus.req_valid  = 4'b1010;
        bus.resp_ready = 1'b1;
        #1;
        tests++; if (bus.req_ready !== 4'b0010 || bus.resp_valid !== 1'b0) begin fails++; $display("FAIL mid_first_grant: got %b/%b want 0010/0", bus.req_ready, bus.resp_valid); end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL mid_stale: got %b want 0", bus.resp_valid); end
        @(negedge clk);
        #1;
        tests++; if (bus.resp_valid !== 1'b1 || bus.resp_dout !== DOUT_W'(15) || bus.resp_id !== 2'd1 || bus.resp_tag !== 4'd9) begin
            fails++; $display("FAIL mid_resp: got %b/%0d/%0d/%0d want 1/15/1/9", bus.resp_valid, bus.resp_dout, bus.resp_id, bus.resp_tag); end
        @(negedge clk);
        #1;
        tests++; if (bus.resp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mid_drained: got %b/%b want 0/0", bus.resp_valid, busy); end
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        rstn           = 1'b1;
        bus.req_valid  = '0;
        bus.req_mode   = '0;
        bus.req_din    = '0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b0;
        #1;
        rstn = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        tests++; if (full_push_seen !== 1'b0) begin fails++; $display("FAIL fifo_push_full: got %b want 0", full_push_seen); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
